// File: rtl/adder_nnbit_ahead_serial_reg.sv
// adder_nnbit_ahead_serial_reg
//   Registered N-bit unsigned adder built from 4-bit carry-lookahead groups.
//   Group carries ripple from one group to the next. Each group computes its
//   internal carries in flattened two-level form. The only state is the output
//   register, so the block is a one-cycle arithmetic stage.
//
// Ports
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high reset; clears o_res/o_cry
//   i_num_a : addend A (unsigned, DATA_WIDTH bits)
//   i_num_b : addend B (unsigned, DATA_WIDTH bits)
//   i_cry   : carry-in to bit 0
//   o_res   : registered sum, {o_cry, o_res} = A + B + cin
//   o_cry   : registered carry-out of the MSB

module adder_nnbit_ahead_serial_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
);

  localparam int NUM_GROUPS = DATA_WIDTH / 4;

  generate
    if ((DATA_WIDTH < 4) || ((DATA_WIDTH % 4) != 0)) begin : g_bad_width
      $error("adder_nnbit_ahead_serial_reg: DATA_WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] w_g;
  logic [DATA_WIDTH-1:0] w_p;
  logic [DATA_WIDTH-1:0] w_sum;
  // w_c[i] is the carry into bit i; w_c[DATA_WIDTH] is the adder carry-out.
  logic [DATA_WIDTH:0]   w_c;

  assign w_g    = i_num_a & i_num_b;
  assign w_p    = i_num_a ^ i_num_b;
  assign w_c[0] = i_cry;

  genvar k;
  generate
    for (k = 0; k < NUM_GROUPS; k++) begin : g_cla
      localparam int LSB = 4 * k;
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic       w_cin;

      assign w_gg  = w_g[LSB +: 4];
      assign w_pp  = w_p[LSB +: 4];
      assign w_cin = w_c[LSB];

      // Each carry depends only on this group's g/p and the group carry-in,
      // so the only serial path is the group-to-group carry.
      assign w_c[LSB+1] = w_gg[0]
                        | (w_pp[0] & w_cin);
      assign w_c[LSB+2] = w_gg[1]
                        | (w_pp[1] & w_gg[0])
                        | (w_pp[1] & w_pp[0] & w_cin);
      assign w_c[LSB+3] = w_gg[2]
                        | (w_pp[2] & w_gg[1])
                        | (w_pp[2] & w_pp[1] & w_gg[0])
                        | (w_pp[2] & w_pp[1] & w_pp[0] & w_cin);
      assign w_c[LSB+4] = w_gg[3]
                        | (w_pp[3] & w_gg[2])
                        | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_cin);
    end
  endgenerate

  assign w_sum = w_p ^ w_c[DATA_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res <= '0;
      o_cry <= 1'b0;
    end else begin
      o_res <= w_sum;
      o_cry <= w_c[DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_nnbit_ahead_serial_reg.sv
// tb_adder_nnbit_ahead_serial_reg
//   Bench for the registered CLA adder at DATA_WIDTH=8 and DATA_WIDTH=16.
//   A reference model based on integer addition tracks the expected register
//   contents. A compare process checks both instances on every falling edge.
//   Directed vectors also carry hand-computed literal expectations.

module tb_adder_nnbit_ahead_serial_reg;

  logic        clk;
  logic        rst;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic [7:0]  res8;
  logic        cry8;
  logic [15:0] a16, b16;
  logic        cin16;
  logic [15:0] res16;
  logic        cry16;

  int checks   = 0;
  int failures = 0;

  adder_nnbit_ahead_serial_reg #(.DATA_WIDTH(8)) u_dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_num_a (a8),
    .i_num_b (b8),
    .i_cry   (cin8),
    .o_res   (res8),
    .o_cry   (cry8)
  );

  adder_nnbit_ahead_serial_reg #(.DATA_WIDTH(16)) u_dut16 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_num_a (a16),
    .i_num_b (b16),
    .i_cry   (cin16),
    .o_res   (res16),
    .o_cry   (cry16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the value the output register must hold after each edge.
  int   m8_res, m16_res;
  logic m8_cry, m16_cry;
  logic m_valid = 1'b0;

  always @(posedge clk) begin
    int s8, s16;
    s8  = int'(a8)  + int'(b8)  + int'(cin8);
    s16 = int'(a16) + int'(b16) + int'(cin16);
    if (rst) begin
      m8_res  <= 0;
      m8_cry  <= 1'b0;
      m16_res <= 0;
      m16_cry <= 1'b0;
    end else begin
      m8_res  <= s8 % 256;
      m8_cry  <= (s8 >= 256);
      m16_res <= s16 % 65536;
      m16_cry <= (s16 >= 65536);
    end
    m_valid <= 1'b1;
  end

  // Compare process: checks every cycle once the model has seen an edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ((int'(res8) != m8_res) || (cry8 !== m8_cry)) begin
        failures++;
        $display("FAIL cmp8 t=%0t got res=%02h cry=%b want res=%02h cry=%b",
                 $time, res8, cry8, m8_res[7:0], m8_cry);
      end
      checks++;
      if ((int'(res16) != m16_res) || (cry16 !== m16_cry)) begin
        failures++;
        $display("FAIL cmp16 t=%0t got res=%04h cry=%b want res=%04h cry=%b",
                 $time, res16, cry16, m16_res[15:0], m16_cry);
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8   = a;
    b8   = b;
    cin8 = c;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a16   = a;
    b16   = b;
    cin16 = c;
  endtask

  task automatic lit8(input string name, input logic [7:0] er, input logic ec);
    @(posedge clk);
    #1;
    checks++;
    if ((res8 !== er) || (cry8 !== ec)) begin
      failures++;
      $display("FAIL %s got res=%02h cry=%b want res=%02h cry=%b", name, res8, cry8, er, ec);
    end
  endtask

  task automatic lit16(input string name, input logic [15:0] er, input logic ec);
    @(posedge clk);
    #1;
    checks++;
    if ((res16 !== er) || (cry16 !== ec)) begin
      failures++;
      $display("FAIL %s got res=%04h cry=%b want res=%04h cry=%b", name, res16, cry16, er, ec);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] r;
    logic       y;
  } vec8_t;

  vec8_t vecs[10] = '{
    '{8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1},
    '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1},
    '{8'hFC, 8'hF9, 1'b0, 8'hF5, 1'b1},
    '{8'hF7, 8'hF6, 1'b0, 8'hED, 1'b1},
    '{8'hF5, 8'hF5, 1'b1, 8'hEB, 1'b1},
    '{8'hFE, 8'hF9, 1'b1, 8'hF8, 1'b1},
    '{8'hF2, 8'hF6, 1'b1, 8'hE9, 1'b1},
    '{8'hF6, 8'hFC, 1'b1, 8'hF3, 1'b1},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
    '{8'h0F, 8'h00, 1'b1, 8'h10, 1'b0}
  };

  initial begin
    rst   = 1'b1;
    a8    = 8'hFF;
    b8    = 8'hFF;
    cin8  = 1'b1;
    a16   = 16'hFFFF;
    b16   = 16'hFFFF;
    cin16 = 1'b1;

    lit8("reset_edge1", 8'h00, 1'b0);
    lit8("reset_edge2", 8'h00, 1'b0);
    lit16("reset16", 16'h0000, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    lit8("reset_release", 8'hFF, 1'b1);

    foreach (vecs[i]) begin
      drive8(vecs[i].a, vecs[i].b, vecs[i].c);
      lit8($sformatf("vec%0d", i), vecs[i].r, vecs[i].y);
    end

    drive16(16'hFFFF, 16'h0001, 1'b0);
    lit16("w16_wrap", 16'h0000, 1'b1);
    drive16(16'h1234, 16'h4321, 1'b1);
    lit16("w16_mix", 16'h5556, 1'b0);
    drive16(16'h00FF, 16'hFF00, 1'b1);
    lit16("w16_propagate", 16'h0000, 1'b1);

    // Back-to-back random operands on both widths; one-cycle reset mid-stream.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8    = 8'($urandom_range(0, 255));
      b8    = 8'($urandom_range(0, 255));
      cin8  = 1'($urandom_range(0, 1));
      a16   = 16'($urandom_range(0, 65535));
      b16   = 16'($urandom_range(0, 65535));
      cin16 = 1'($urandom_range(0, 1));
      rst   = (n == 500);
      if (n == 500) begin
        lit8("midstream_reset8", 8'h00, 1'b0);
        checks++;
        if ((res16 !== 16'h0000) || (cry16 !== 1'b0)) begin
          failures++;
          $display("FAIL midstream_reset16 got res=%04h cry=%b want res=0000 cry=0", res16, cry16);
        end
      end
    end

    @(negedge clk);
    rst  = 1'b0;
    a8   = 8'h3C;
    b8   = 8'h4B;
    cin8 = 1'b0;
    lit8("post_stream", 8'h87, 1'b0);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_nnbit_ahead_serial_reg.md
# adder_nnbit_ahead_serial_reg

Parameterised N-bit adder built from 4-bit carry-lookahead (CLA) groups. Group carries ripple serially from one group to the next. The sum and carry-out are captured in an output register, so the block drops into a clocked datapath wherever a one-cycle arithmetic stage is needed, such as an ALU add/sub path. The core is purely combinational, and the only state is the output register.

## Interface
Parameters:
- DATA_WIDTH, default 8: operand and result width in bits.
  - Must be a positive multiple of 4.
  - Other values are illegal, and elaboration fails via a generate-time check.

Ports:
- i_clk, input, 1: rising-edge clock.
- i_rst, input, 1: reset. Synchronous and active-high; one clock domain.
- i_num_a, input, DATA_WIDTH: addend A, unsigned.
- i_num_b, input, DATA_WIDTH: addend B, unsigned.
- i_cry, input, 1: carry-in to bit 0.
- o_res, output, DATA_WIDTH: registered sum, {o_cry, o_res} = A + B + cin mod 2^(DATA_WIDTH+1).
- o_cry, output, 1: registered carry-out of the MSB.

## Operation
- Bit level:
  - Per-bit generate is g[i] = a[i] & b[i].
  - Per-bit propagate is p[i] = a[i] ^ b[i].
- 4-bit CLA group k covers bits 4k..4k+3, with group carry-in c0:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - cout = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
  - Every carry is computed in flattened two-level form. The carries do not ripple inside the group.
  - Sum bit s[i] = p[i] ^ c[i].
- Serial group chain:
  - Group 0 carry-in is i_cry.
  - Group k carry-in is the cout of group k-1.
  - The cout of the last group is the adder carry-out.
  - The number of groups is DATA_WIDTH/4, built with a generate loop.
- The arithmetic is unsigned. There is no overflow flag: a signed-overflow flag, if needed, is derived outside this block.
- Register:
  - On each rising i_clk with i_rst=0, o_res takes the combinational sum and o_cry takes the final carry.
  - The register is loaded every cycle. There is no enable.
- Reset: with i_rst=1 at a rising edge, o_res=0 and o_cry=0. Reset has priority over loading.
- Result integrity: the result must match A+B+cin exactly for all operand values, including the all-ones operands and the full carry-propagate case (A=~B, cin=1).

## Timing
- Latency is 1 cycle. Operands applied before edge n appear on o_res/o_cry after edge n.
- Throughput is one add per cycle. The operands may change every cycle.
- Output reset value: o_res=0, o_cry=0. Outputs stay 0 for every cycle that i_rst is high at the edge.
- Reset asserted mid-stream: the next edge clears the outputs, and the in-flight result is discarded.
- Reset deasserted: the first edge with i_rst=0 loads the sum of the operands present at that edge.
- Combinational critical path, from i_num_a/i_num_b/i_cry to the register D inputs:
  - One group's g/p and lookahead logic.
  - Plus (DATA_WIDTH/4 − 1) serial group-carry stages.
  - Plus the sum XOR.
- The outputs are glitch-free between edges, because they are registered.

## Test plan
- Reset check:
  - Hold i_rst=1 for 2 cycles with A=0xFF, B=0xFF, cin=1: o_res=0x00, o_cry=0.
  - Release reset: the next edge gives o_res=0xFF, o_cry=1.
- Directed vectors, DATA_WIDTH=8, cin=0, each checked one cycle after it is applied:
  - 0xF0+0xF0 → res=0xE0, cry=1
  - 0xFF+0xFF → res=0xFE, cry=1
  - 0xFC+0xF9 → res=0xF5, cry=1
  - 0xF7+0xF6 → res=0xED, cry=1
- Directed vectors with cin=1:
  - 0xF5+0xF5 → 0xEB, cry=1
  - 0xFE+0xF9 → 0xF8, cry=1
  - 0xF2+0xF6 → 0xE9, cry=1
  - 0xF6+0xFC → 0xF3, cry=1
- Full propagate across the group boundary:
  - 0xFF+0x00, cin=1 → res=0x00, cry=1.
  - 0x0F+0x00, cin=1 → res=0x10, cry=0, which exercises the group-0 to group-1 carry.
- Back-to-back and mid-stream reset:
  - Change operands every cycle and check each result exactly one cycle later.
  - Assert i_rst for one cycle mid-stream: the outputs read 0 that cycle, then resume.
- Width scaling, DATA_WIDTH=16:
  - 0xFFFF+0x0001, cin=0 → 0x0000, cry=1.
  - 0x1234+0x4321, cin=1 → 0x5556, cry=0.
  - Plus 1000 random vectors compared against a behavioural A+B+cin model.
